video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Free-running raster timing generator on the video pixel clock.
//  Sits directly upstream of the AXI4-Stream-to-video output stage: drives its video_*_i timing inputs
//  (hsync, vsync, hblank, vblank, de). The rising edge of vsync arms that stage's FIFO read/write start.
//  Adds a frame-start pulse and active-pixel coordinates for downstream overlay logic.
//  Line order: active, front porch, sync, back porch. Frame order is the same, counted in lines.
// PARAMETERS
//  H_ACTIVE 1920  active pixels per line
//  H_FP     88    horizontal front porch, pixels
//  H_SYNC   44    hsync width, pixels
//  H_BP     148   horizontal back porch, pixels
//  V_ACTIVE 1080  active lines per frame
//  V_FP     4     vertical front porch, lines
//  V_SYNC   5     vsync width, lines
//  V_BP     36    vertical back porch, lines
//  HS_POL   1     hsync active level (1 = active high)
//  VS_POL   1     vsync active level (1 = active high)
//  CW       12    counter/coordinate width; H_TOTAL and V_TOTAL must be <= 2**CW
// PORTS
//  video_clk      in  1   pixel clock; sole clock
//  video_rst      in  1   synchronous reset, active high
//  timing_en      in  1   1 = run; 0 = hold at frame origin, outputs idle
//  video_hsync_o  out 1   horizontal sync, polarity HS_POL
//  video_vsync_o  out 1   vertical sync, polarity VS_POL
//  video_hblank_o out 1   1 outside active pixels of a line
//  video_vblank_o out 1   1 outside active lines of a frame
//  video_de_o     out 1   1 = active pixel (= !hblank & !vblank)
//  frame_start_o  out 1   one-cycle pulse, coincident with first de of a frame
//  pix_x          out CW  active pixel column, valid when de=1
//  pix_y          out CW  active pixel row, valid when de=1
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Every parameter must be >= 1.
//  - Reset and timing_en=0 both give the same idle state:
//    - h_cnt = v_cnt = 0;
//    - hsync = !HS_POL, vsync = !VS_POL;
//    - hblank = vblank = 1, de = 0, frame_start = 0;
//    - pix_x = pix_y = 0.
//  - Running (timing_en=1), h_cnt advances by 1 each clock. At H_TOTAL-1 it wraps to 0 and v_cnt advances.
//  - v_cnt wraps from V_TOTAL-1 to 0 on the same clock as the h wrap. Both wraps happen on one edge.
//  - All outputs are registered decodes of the current (h_cnt, v_cnt): 1 cycle latency from counter to pin.
//    - hblank = h_cnt >= H_ACTIVE
//    - vblank = v_cnt >= V_ACTIVE
//    - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
//    - vsync active for whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. It changes only at line start (h_cnt = 0 decode).
//    - de = !hblank & !vblank
//    - frame_start = (h_cnt == 0 && v_cnt == 0)
//    - pix_x = h_cnt and pix_y = v_cnt when active, otherwise hold the last value
//  - First pixel: de and frame_start rise 1 cycle after the first clock with timing_en=1 (decode of counter 0,0).
//  - Deasserting timing_en mid-frame:
//    - counters clear on that edge;
//    - outputs reach idle values 1 cycle later;
//    - re-enable restarts at the frame origin. Partial frames are not resumed.
//  - video_rst has priority over timing_en.
//  - Line and frame periods are exact. No dropped or repeated counts at wrap.
// TESTING  (small parameters: H 8/2/3/2 -> H_TOTAL 15; V 4/1/2/1 -> V_TOTAL 8; POL 1)
//  1 Reset held 3 cycles, then timing_en=1 -> idle values during reset; first de=1 and frame_start=1 on cycle 1 after enable, pix_x=0, pix_y=0.
//  2 Run one line -> de high 8 cycles (pix_x 0..7); hblank high 7 cycles; hsync high on h_cnt 10..12 only.
//  3 Run 2 full frames -> frame period 120 cycles; vblank on lines 4..7; vsync high lines 5..6 (30 cycles, edges at line start); frame_start exactly once per frame.
//  4 Drop timing_en at h_cnt=5, v_cnt=2 for 4 cycles, then re-raise -> outputs idle 1 cycle after drop; next de is pix (0,0) with frame_start.
//  5 Assert video_rst mid-vsync -> next cycle vsync=0, hblank=vblank=1, de=0; counting restarts from (0,0).
//  6 HS_POL=0, VS_POL=0 -> sync levels inverted, idle sync level 1; blank/de unchanged.

Source files
------------

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: pixel/line counters plus registered
// sync, blank, data-enable, frame-start and active-pixel coordinate outputs.
module video_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CW       = 12
) (
   input  logic          video_clk,
   input  logic          video_rst,
   input  logic          timing_en,
   output logic          video_hsync_o,
   output logic          video_vsync_o,
   output logic          video_hblank_o,
   output logic          video_vblank_o,
   output logic          video_de_o,
   output logic          frame_start_o,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Every boundary is below the total, so all of them fit in CW bits.
   localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] H_ACT_END    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] V_ACT_END    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] ONE          = CW'(1);

   logic [CW-1:0] r_hCnt;
   logic [CW-1:0] r_vCnt;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_hblank;
   logic          r_vblank;
   logic          r_de;
   logic          r_frameStart;
   logic [CW-1:0] r_pixX;
   logic [CW-1:0] r_pixY;

   logic w_idle;
   logic w_hBlank;
   logic w_vBlank;
   logic w_hSyncOn;
   logic w_vSyncOn;
   logic w_de;
   logic w_origin;

   assign w_idle    = video_rst || !timing_en;
   assign w_hBlank  = r_hCnt >= H_ACT_END;
   assign w_vBlank  = r_vCnt >= V_ACT_END;
   assign w_hSyncOn = (r_hCnt >= H_SYNC_START) && (r_hCnt < H_SYNC_END);
   assign w_vSyncOn = (r_vCnt >= V_SYNC_START) && (r_vCnt < V_SYNC_END);
   assign w_de      = !w_hBlank && !w_vBlank;
   assign w_origin  = (r_hCnt == '0) && (r_vCnt == '0);

   // Both counters wrap on the same edge at the end of the last line.
   always_ff @(posedge video_clk) begin
      if (w_idle) begin
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (r_hCnt == H_LAST) begin
         r_hCnt <= '0;
         r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + ONE;
      end else begin
         r_hCnt <= r_hCnt + ONE;
      end
   end

   // Outputs decode the counter value present before this edge, so pins lag counters by one cycle.
   always_ff @(posedge video_clk) begin
      if (w_idle) begin
         r_hsync      <= ~HS_POL;
         r_vsync      <= ~VS_POL;
         r_hblank     <= 1'b1;
         r_vblank     <= 1'b1;
         r_de         <= 1'b0;
         r_frameStart <= 1'b0;
         r_pixX       <= '0;
         r_pixY       <= '0;
      end else begin
         r_hsync      <= w_hSyncOn ^ ~HS_POL;
         r_vsync      <= w_vSyncOn ^ ~VS_POL;
         r_hblank     <= w_hBlank;
         r_vblank     <= w_vBlank;
         r_de         <= w_de;
         r_frameStart <= w_origin;
         if (w_de) begin
            r_pixX <= r_hCnt;
            r_pixY <= r_vCnt;
         end
      end
   end

   assign video_hsync_o  = r_hsync;
   assign video_vsync_o  = r_vsync;
   assign video_hblank_o = r_hblank;
   assign video_vblank_o = r_vblank;
   assign video_de_o     = r_de;
   assign frame_start_o  = r_frameStart;
   assign pix_x          = r_pixX;
   assign pix_y          = r_pixY;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a positive- and a negative-polarity instance run in
// lockstep against a raster model that derives position from elapsed run time.
module tb_video_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int CW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   logic pHs, pVs, pHb, pVb, pDe, pFs;
   logic nHs, nVs, nHb, nVb, nDe, nFs;
   logic [CW-1:0] pPx, pPy, nPx, nPy;

   int passCount = 0;
   int checkCount = 0;
   int cyc = 0;

   // Model state: cycles spent running since the last origin, plus expected pins.
   int t = 0;
   logic eHb, eVb, eDe, eFs, eHsAct, eVsAct;
   logic [CW-1:0] ePx, ePy;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
   ) dutP (
      .video_clk(clk), .video_rst(rst), .timing_en(en),
      .video_hsync_o(pHs), .video_vsync_o(pVs),
      .video_hblank_o(pHb), .video_vblank_o(pVb),
      .video_de_o(pDe), .frame_start_o(pFs),
      .pix_x(pPx), .pix_y(pPy)
   );

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
   ) dutN (
      .video_clk(clk), .video_rst(rst), .timing_en(en),
      .video_hsync_o(nHs), .video_vsync_o(nVs),
      .video_hblank_o(nHb), .video_vblank_o(nVb),
      .video_de_o(nDe), .frame_start_o(nFs),
      .pix_x(nPx), .pix_y(nPy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   function automatic int curH();
      return t % HT;
   endfunction

   function automatic int curV();
      return (t / HT) % VT;
   endfunction

   // Expected pins after an edge sampled with inputs (r, e).
   task automatic modelEdge(input logic r, input logic e);
      int h, v;
      if (r || !e) begin
         eHb = 1'b1; eVb = 1'b1; eDe = 1'b0; eFs = 1'b0;
         eHsAct = 1'b0; eVsAct = 1'b0; ePx = '0; ePy = '0;
         t = 0;
      end else begin
         h = curH();
         v = curV();
         eHb    = (h >= HA);
         eVb    = (v >= VA);
         eHsAct = (h >= HA + HF) && (h < HA + HF + HS);
         eVsAct = (v >= VA + VF) && (v < VA + VF + VS);
         eDe    = !eHb && !eVb;
         eFs    = (h == 0) && (v == 0);
         if (eDe) begin
            ePx = CW'(h);
            ePy = CW'(v);
         end
         t = (t + 1) % (HT * VT);
      end
   endtask

   task automatic compareAll();
      checkOutput("p_hsync",  32'(pHs), 32'(eHsAct));
      checkOutput("p_vsync",  32'(pVs), 32'(eVsAct));
      checkOutput("n_hsync",  32'(nHs), 32'(!eHsAct));
      checkOutput("n_vsync",  32'(nVs), 32'(!eVsAct));
      checkOutput("p_hblank", 32'(pHb), 32'(eHb));
      checkOutput("p_vblank", 32'(pVb), 32'(eVb));
      checkOutput("n_hblank", 32'(nHb), 32'(eHb));
      checkOutput("n_vblank", 32'(nVb), 32'(eVb));
      checkOutput("p_de",     32'(pDe), 32'(eDe));
      checkOutput("n_de",     32'(nDe), 32'(eDe));
      checkOutput("p_fs",     32'(pFs), 32'(eFs));
      checkOutput("n_fs",     32'(nFs), 32'(eFs));
      checkOutput("p_pix_x",  32'(pPx), 32'(ePx));
      checkOutput("p_pix_y",  32'(pPy), 32'(ePy));
      checkOutput("n_pix_x",  32'(nPx), 32'(ePx));
      checkOutput("n_pix_y",  32'(nPy), 32'(ePy));
   endtask

   task automatic applyStimulus(input logic r, input logic e);
      rst = r;
      en  = e;
      @(posedge clk);
      cyc++;
      modelEdge(r, e);
      #1;
      compareAll();
   endtask

   // Run until the counters sit at (h, v), so the next edge decodes that position.
   task automatic runUntil(input int h, input int v);
      int budget = 2 * HT * VT;
      while (!(curH() == h && curV() == v) && budget > 0) begin
         applyStimulus(1'b0, 1'b1);
         budget--;
      end
      if (budget == 0) begin
         checkCount++;
         $display("[TB] FAIL runUntil: position (%0d,%0d) not reached within cycle budget", h, v);
      end
   endtask

   initial begin
      int deCount, hbCount, hsCount, fsCount, vsCount, fsFirst, fsSecond;

      // Reset has priority over an asserted enable.
      repeat (3) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("first_de", 32'(pDe), 32'd1);
      checkOutput("first_fs", 32'(pFs), 32'd1);
      checkOutput("first_px", 32'(pPx), 32'd0);

      deCount = int'(pDe);
      hbCount = int'(pHb);
      hsCount = int'(pHs);
      repeat (HT - 1) begin
         applyStimulus(1'b0, 1'b1);
         deCount += int'(pDe);
         hbCount += int'(pHb);
         hsCount += int'(pHs);
      end
      checkOutput("line_de_cycles", 32'(deCount), 32'd8);
      checkOutput("line_hblank_cycles", 32'(hbCount), 32'd7);
      checkOutput("line_hsync_cycles", 32'(hsCount), 32'd3);

      fsCount = 0; vsCount = 0; fsFirst = -1; fsSecond = -1;
      repeat (2 * HT * VT) begin
         applyStimulus(1'b0, 1'b1);
         vsCount += int'(pVs);
         if (pFs) begin
            fsCount++;
            if (fsFirst < 0) fsFirst = cyc;
            else if (fsSecond < 0) fsSecond = cyc;
         end
      end
      checkOutput("frame_start_count", 32'(fsCount), 32'd2);
      checkOutput("vsync_cycles_2frames", 32'(vsCount), 32'd60);
      checkOutput("frame_period", 32'(fsSecond - fsFirst), 32'd120);

      // Enable drop mid-frame, then restart from the origin.
      runUntil(5, 2);
      applyStimulus(1'b0, 1'b0);
      checkOutput("drop_de", 32'(pDe), 32'd0);
      checkOutput("drop_hblank", 32'(pHb), 32'd1);
      repeat (3) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("restart_fs", 32'(pFs), 32'd1);
      checkOutput("restart_px", 32'(pPx), 32'd0);
      checkOutput("restart_py", 32'(pPy), 32'd0);

      // Reset in the middle of vsync.
      runUntil(7, 5);
      applyStimulus(1'b0, 1'b1);
      checkOutput("pre_rst_vsync", 32'(pVs), 32'd1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("rst_vsync", 32'(pVs), 32'd0);
      checkOutput("rst_n_vsync", 32'(nVs), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_rst_fs", 32'(pFs), 32'd1);

      repeat (3000) begin
         applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) != 0));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
